// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data ports.
// Data wins ties; after STARVE_LIMIT data grants past a waiting fetch, the fetch wins.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            dbg_state
);

    // req/gnt: a requester holds req and its operands stable until gnt. gnt is
    // combinational, asserted only in IDLE, at most one per cycle; the request
    // is taken at the clock edge ending the gnt cycle, and req still high after
    // that edge is a new request. Dropping req before gnt cancels it.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [2:0] LAT_INIT   = 3'(READ_LATENCY);

    state_e                state_q, state_d;
    logic [3:0]            starve_q, starve_d;
    logic [2:0]            lat_q, lat_d;
    logic                  owner_d_q, owner_d_d;  // 1: data port owns the access
    logic                  op_we_q, op_we_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic                  d_rvalid_q, d_rvalid_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  if_gnt_c, d_gnt_c;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        lat_d       = lat_q;
        owner_d_d   = owner_d_q;
        op_we_d     = op_we_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        if_gnt_c    = 1'b0;
        d_gnt_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_req && (!d_req || starve_q == STARVE_MAX)) begin
                    if_gnt_c   = 1'b1;
                    starve_d   = 4'd0;
                    mem_addr_d = if_addr;
                    owner_d_d  = 1'b0;
                    op_we_d    = 1'b0;
                    state_d    = S_ADDR;
                end else if (d_req) begin
                    d_gnt_c     = 1'b1;
                    // Only grants that overtake a waiting fetch count towards starvation.
                    if (!if_req) begin
                        starve_d = 4'd0;
                    end else if (starve_q < STARVE_MAX) begin
                        starve_d = starve_q + 4'd1;
                    end
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_we_d    = d_we;
                    owner_d_d   = 1'b1;
                    op_we_d     = d_we;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: begin
                if (op_we_q) begin
                    state_d = S_IDLE;
                end else begin
                    lat_d   = LAT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    if (owner_d_q) begin
                        d_rdata_d  = mem_rdata;
                        d_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            starve_q    <= 4'd0;
            lat_q       <= 3'd0;
            owner_d_q   <= 1'b0;
            op_we_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            lat_q       <= lat_d;
            owner_d_q   <= owner_d_d;
            op_we_q     <= op_we_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_gnt    = if_gnt_c;
    assign d_gnt     = d_gnt_c;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed grant table, hand sequences for the timing
// corners, and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int RL_A = 1;
    localparam int RL_B = 2;
    localparam int SL   = 4;

    logic        clk;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;

    logic        b_if_req;
    logic [31:0] b_if_addr;
    logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_we;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [1:0]  b_dbg_state;

    logic        pre_en_a, pre_en_b;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    int          checks, errors, cyc;
    logic [31:0] ref_mem [256];

    mem_arbiter #(.READ_LATENCY(RL_A), .STARVE_LIMIT(SL)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    mem_arbiter #(.READ_LATENCY(RL_B), .STARVE_LIMIT(SL)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .dbg_state(b_dbg_state)
    );

    // Memories with a READ_LATENCY-deep read pipeline; preload shares the write port.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] pipe_a [RL_A];
    logic [31:0] pipe_b [RL_B];

    always @(posedge clk) begin
        if (pre_en_a) mem_a[pre_addr] <= pre_data;
        else if (mem_we) mem_a[mem_addr[7:0]] <= mem_wdata;
        if (pre_en_b) mem_b[pre_addr] <= pre_data;
        else if (b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
        pipe_a[0] <= mem_a[mem_addr[7:0]];
        for (int i = 1; i < RL_A; i++) pipe_a[i] <= pipe_a[i-1];
        pipe_b[0] <= mem_b[b_mem_addr[7:0]];
        for (int i = 1; i < RL_B; i++) pipe_b[i] <= pipe_b[i-1];
        cyc <= cyc + 1;
    end
    assign mem_rdata   = pipe_a[RL_A-1];
    assign b_mem_rdata = pipe_b[RL_B-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic sel_b, input logic [7:0] a, input logic [31:0] v);
        pre_addr = a;
        pre_data = v;
        pre_en_a = !sel_b;
        pre_en_b = sel_b;
        next_cycle();
        pre_en_a = 1'b0;
        pre_en_b = 1'b0;
        if (!sel_b) ref_mem[a] = v;
    endtask

    typedef struct {
        logic        i_req;
        logic        dq;
        logic        we;
        logic [31:0] addr;
        logic        e_ig;
        logic        e_dg;
    } vec_t;

    vec_t        tbl [11];
    logic [1:0]  pat [10];
    logic [31:0] words [8];
    logic [31:0] if_exp_q [$];
    logic [31:0] d_exp_q [$];
    int          if_due_q [$];
    int          d_due_q [$];
    int          g, budget, pulses, n_gnt, n_rv, last_g;
    int          next_ok, we_cyc, addr_cyc, starve_m;
    logic [31:0] exp_addr, got_data;
    logic        eig, edg, gseen;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0;
        if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
        b_if_req = 0; b_if_addr = 0;
        pre_en_a = 0; pre_en_b = 0; pre_addr = 0; pre_data = 0;

        // ---- reset values ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_if_gnt", if_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_state", dbg_state, 0);
        next_cycle();
        rst = 1'b1;

        // ---- grant decision table; starvation count carries across rows ----
        tbl[0]  = '{0, 0, 0, 32'h50, 0, 0};
        tbl[1]  = '{1, 0, 0, 32'h50, 1, 0};
        tbl[2]  = '{0, 1, 1, 32'h50, 0, 1};
        tbl[3]  = '{1, 1, 0, 32'h50, 0, 1};
        tbl[4]  = '{0, 1, 0, 32'h50, 0, 1};
        tbl[5]  = '{1, 1, 1, 32'h50, 0, 1};
        tbl[6]  = '{1, 1, 0, 32'h50, 0, 1};
        tbl[7]  = '{1, 1, 1, 32'h50, 0, 1};
        tbl[8]  = '{1, 1, 0, 32'h50, 0, 1};
        tbl[9]  = '{1, 1, 0, 32'h50, 1, 0};
        tbl[10] = '{1, 1, 1, 32'h50, 0, 1};
        for (int i = 0; i < 11; i++) begin
            next_cycle();
            if_req = tbl[i].i_req; d_req = tbl[i].dq; d_we = tbl[i].we;
            if_addr = tbl[i].addr; d_addr = tbl[i].addr; d_wdata = 32'h5A5A0000 + i;
            @(negedge clk);
            check($sformatf("tbl%0d_if_gnt", i), if_gnt, tbl[i].e_ig);
            check($sformatf("tbl%0d_d_gnt", i), d_gnt, tbl[i].e_dg);
            next_cycle();
            if_req = 0; d_req = 0;
            repeat (4) next_cycle();
        end

        // ---- single fetch ----
        preload(1'b0, 8'h10, 32'hDEADBEEF);
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        check("fetch_if_gnt", if_gnt, 1);
        check("fetch_d_gnt", d_gnt, 0);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            if (k == 1) if_req = 0;
            @(negedge clk);
            if (k == 1) begin
                check("fetch_mem_addr", mem_addr, 32'h10);
                check("fetch_mem_we", mem_we, 0);
            end
            check($sformatf("fetch_if_rvalid_t%0d", k), if_rvalid, k == 3);
            check($sformatf("fetch_d_rvalid_t%0d", k), d_rvalid, 0);
        end
        check("fetch_if_rdata", if_rdata, 32'hDEADBEEF);

        // ---- write then read ----
        next_cycle();
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
        @(negedge clk);
        check("wr_d_gnt", d_gnt, 1);
        next_cycle();
        d_req = 0;
        @(negedge clk);
        check("wr_mem_we_t1", mem_we, 1);
        check("wr_mem_addr", mem_addr, 32'h20);
        check("wr_mem_wdata", mem_wdata, 32'h12345678);
        next_cycle();
        @(negedge clk);
        check("wr_mem_we_t2", mem_we, 0);
        next_cycle();
        d_req = 1; d_we = 0; d_addr = 32'h20;
        @(negedge clk);
        check("rd_d_gnt", d_gnt, 1);
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            if (k == 1) d_req = 0;
            @(negedge clk);
            if (d_rvalid) begin
                pulses++;
                got_data = d_rdata;
            end
        end
        check("rd_pulses", pulses, 1);
        check("rd_d_rdata", d_rdata, 32'h12345678);

        // ---- simultaneous requests: data first, fetch at T+3 ----
        next_cycle();
        if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h20;
        @(negedge clk);
        check("sim_d_gnt", d_gnt, 1);
        check("sim_if_gnt_t0", if_gnt, 0);
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            if (k == 1) d_req = 0;
            if (k == 4) if_req = 0;
            @(negedge clk);
            check($sformatf("sim_if_gnt_t%0d", k), if_gnt, k == 3);
            check($sformatf("sim_d_rvalid_t%0d", k), d_rvalid, k == 3);
            check($sformatf("sim_if_rvalid_t%0d", k), if_rvalid, k == 6);
        end
        check("sim_d_rdata", d_rdata, 32'h12345678);
        check("sim_if_rdata", if_rdata, 32'hDEADBEEF);

        // ---- starvation: D,D,D,D,I repeating ----
        pat[0] = 2'b01; pat[1] = 2'b01; pat[2] = 2'b01; pat[3] = 2'b01; pat[4] = 2'b10;
        pat[5] = 2'b01; pat[6] = 2'b01; pat[7] = 2'b01; pat[8] = 2'b01; pat[9] = 2'b10;
        next_cycle();
        if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h20;
        g = 0; budget = 0;
        while (g < 10 && budget < 100) begin
            @(negedge clk);
            budget++;
            if (if_gnt || d_gnt) begin
                check($sformatf("starve_grant%0d", g), {if_gnt, d_gnt}, pat[g]);
                g++;
            end
            next_cycle();
        end
        if_req = 0; d_req = 0;
        check("starve_grant_count", g, 10);
        repeat (6) next_cycle();

        // ---- async reset during a write's ADDR cycle ----
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hCAFE0001;
        @(negedge clk);
        check("abw_d_gnt", d_gnt, 1);
        next_cycle();
        d_req = 0;
        check("abw_mem_we_pre", mem_we, 1);
        #1 rst = 1'b0;
        #1;
        check("abw_mem_we_async", mem_we, 0);
        check("abw_mem_addr_async", mem_addr, 0);
        check("abw_mem_wdata_async", mem_wdata, 0);
        next_cycle();
        rst = 1'b1;

        // ---- async reset during a read's WAIT cycle ----
        next_cycle();
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        check("abr_if_gnt", if_gnt, 1);
        next_cycle();
        if_req = 0;
        next_cycle();
        #1 rst = 1'b0;
        #1;
        check("abr_state_async", dbg_state, 0);
        check("abr_mem_addr_async", mem_addr, 0);
        check("abr_if_rdata_async", if_rdata, 0);
        check("abr_d_rdata_async", d_rdata, 0);
        check("abr_if_rvalid_async", if_rvalid, 0);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        check("abr_first_gnt", if_gnt, 1);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            if (k == 1) if_req = 0;
            @(negedge clk);
            check($sformatf("abr_if_rvalid_t%0d", k), if_rvalid, k == 3);
            check($sformatf("abr_d_rvalid_t%0d", k), d_rvalid, 0);
        end
        check("abr_if_rdata", if_rdata, 32'hDEADBEEF);

        // ---- back-to-back fetches, READ_LATENCY = 2 ----
        for (int i = 0; i < 8; i++) begin
            words[i] = $urandom;
            preload(1'b1, 8'(i), words[i]);
        end
        b_if_req = 1; b_if_addr = 0;
        n_gnt = 0; n_rv = 0; last_g = 0; budget = 0;
        while (n_rv < 8 && budget < 80) begin
            @(negedge clk);
            budget++;
            gseen = b_if_gnt;
            if (gseen) begin
                if (n_gnt > 0) check($sformatf("b2b_interval%0d", n_gnt), cyc - last_g, RL_B + 2);
                last_g = cyc;
                n_gnt++;
            end
            if (b_if_rvalid) begin
                check($sformatf("b2b_rdata%0d", n_rv), b_if_rdata, words[n_rv]);
                n_rv++;
            end
            next_cycle();
            if (gseen) begin
                if (n_gnt == 8) b_if_req = 0;
                else b_if_addr = n_gnt;
            end
        end
        b_if_req = 0;
        check("b2b_grants", n_gnt, 8);
        check("b2b_responses", n_rv, 8);

        // ---- randomized traffic against a transaction-level model ----
        for (int i = 0; i < 64; i++) preload(1'b0, 8'(i), $urandom);
        repeat (4) next_cycle();
        next_ok = 0; we_cyc = -1; addr_cyc = -1; starve_m = 0; exp_addr = 0;
        for (int n = 0; n < 700; n++) begin
            @(negedge clk);
            eig = 0; edg = 0;
            if (cyc >= next_ok) begin
                if (if_req && (!d_req || starve_m == SL)) eig = 1;
                else if (d_req) edg = 1;
            end
            check("rnd_if_gnt", if_gnt, eig);
            check("rnd_d_gnt", d_gnt, edg);
            check("rnd_mem_we", mem_we, cyc == we_cyc);
            if (cyc == addr_cyc) check("rnd_mem_addr", mem_addr, exp_addr);
            if (if_due_q.size() > 0 && if_due_q[0] == cyc) begin
                check("rnd_if_rvalid", if_rvalid, 1);
                check("rnd_if_rdata", if_rdata, if_exp_q[0]);
                void'(if_due_q.pop_front());
                void'(if_exp_q.pop_front());
            end else begin
                check("rnd_if_rvalid_idle", if_rvalid, 0);
            end
            if (d_due_q.size() > 0 && d_due_q[0] == cyc) begin
                check("rnd_d_rvalid", d_rvalid, 1);
                check("rnd_d_rdata", d_rdata, d_exp_q[0]);
                void'(d_due_q.pop_front());
                void'(d_exp_q.pop_front());
            end else begin
                check("rnd_d_rvalid_idle", d_rvalid, 0);
            end
            if (eig) begin
                if_exp_q.push_back(ref_mem[if_addr[7:0]]);
                if_due_q.push_back(cyc + 2 + RL_A);
                next_ok = cyc + 2 + RL_A;
                addr_cyc = cyc + 1; exp_addr = if_addr;
                starve_m = 0;
            end
            if (edg) begin
                addr_cyc = cyc + 1; exp_addr = d_addr;
                if (d_we) begin
                    ref_mem[d_addr[7:0]] = d_wdata;
                    we_cyc = cyc + 1;
                    next_ok = cyc + 2;
                end else begin
                    d_exp_q.push_back(ref_mem[d_addr[7:0]]);
                    d_due_q.push_back(cyc + 2 + RL_A);
                    next_ok = cyc + 2 + RL_A;
                end
                starve_m = if_req ? ((starve_m < SL) ? starve_m + 1 : SL) : 0;
            end
            next_cycle();
            if (n >= 680) begin
                if_req = 0; d_req = 0;
            end else begin
                if (!if_req || eig) begin
                    if_req = ($urandom_range(0, 99) < 60);
                    if_addr = $urandom_range(0, 63);
                end else if ($urandom_range(0, 99) < 4) begin
                    if_req = 0;
                end
                if (!d_req || edg) begin
                    d_req = ($urandom_range(0, 99) < 70);
                    d_we = ($urandom_range(0, 99) < 40);
                    d_addr = $urandom_range(0, 63);
                    d_wdata = $urandom;
                end else if ($urandom_range(0, 99) < 4) begin
                    d_req = 0;
                end
            end
        end
        check("rnd_if_drained", if_due_q.size(), 0);
        check("rnd_d_drained", d_due_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
